// File: rtl/tank_hit_resolver.sv
// tank_hit_resolver
//   Receiving end of the bullet interface for one player's tank. It checks the
//   opponent bullet against this tank and against this player's own bullet. It
//   then returns one-frame kill strobes to the bullets. It also owns the tank's
//   health, armor and post-hit invulnerability. Everything is clocked on the
//   per-frame tick.
//
//   Optional feature macro: HIT_REGEN_EN
//     When defined, health regenerates by +1 after each REGEN_FRAMES quiet frames
//     spent in ALIVE while below MAX_HEALTH. When undefined, health only ever
//     decreases and no regen counter exists.
//
// Parameters
//   MAX_HEALTH     health loaded at reset (1..7)
//   INVULN_FRAMES  frames of invulnerability after a hit (1..255)
//   REGEN_FRAMES   frames per +1 health when HIT_REGEN_EN is defined (1..1023)
//
// Ports
//   frame_clk                      in   frame tick clock
//   Reset_n                        in   asynchronous active-low reset
//   BulletX/BulletY/BulletS        in   opponent bullet centre and half-size
//   bullet_on                      in   opponent bullet in flight
//   OwnBulletX/OwnBulletY/OwnBulletS in this player's bullet centre and half-size
//   own_bullet_on                  in   this player's bullet in flight
//   TankX/TankY/TankS              in   this tank centre and half-size
//   armor_pickup                   in   one-frame pulse, armor collected
//   player_hit                     out  pulse: unarmored tank was hit
//   armor_hit                      out  pulse: armor absorbed a hit
//   bullet_on_bullet_hit           out  pulse: the two bullets collided
//   health                         out  current health
//   armor_on                       out  armor held
//   invuln                         out  tank is invulnerable
//   dead                           out  tank is dead (sticky until reset)

module tank_hit_resolver #(
    parameter int MAX_HEALTH    = 3,
    parameter int INVULN_FRAMES = 60,
    parameter int REGEN_FRAMES  = 600
) (
    input  logic       frame_clk,
    input  logic       Reset_n,
    input  logic [9:0] BulletX,
    input  logic [9:0] BulletY,
    input  logic [9:0] BulletS,
    input  logic       bullet_on,
    input  logic [9:0] OwnBulletX,
    input  logic [9:0] OwnBulletY,
    input  logic [9:0] OwnBulletS,
    input  logic       own_bullet_on,
    input  logic [9:0] TankX,
    input  logic [9:0] TankY,
    input  logic [9:0] TankS,
    input  logic       armor_pickup,
    output logic       player_hit,
    output logic       armor_hit,
    output logic       bullet_on_bullet_hit,
    output logic [2:0] health,
    output logic       armor_on,
    output logic       invuln,
    output logic       dead
);

    typedef enum logic [1:0] {
        ALIVE  = 2'd0,
        INVULN = 2'd1,
        DEAD   = 2'd2
    } state_t;

    localparam logic [2:0] HEALTH_MAX  = 3'(MAX_HEALTH);
    localparam logic [7:0] INVULN_LAST = 8'(INVULN_FRAMES - 1);

    // Elaboration-time guards on the parameter ranges.
    if (MAX_HEALTH < 1 || MAX_HEALTH > 7) begin : g_bad_max_health
        $error("tank_hit_resolver: MAX_HEALTH must be 1..7");
    end
    if (INVULN_FRAMES < 1 || INVULN_FRAMES > 255) begin : g_bad_invuln_frames
        $error("tank_hit_resolver: INVULN_FRAMES must be 1..255");
    end
    if (REGEN_FRAMES < 1 || REGEN_FRAMES > 1023) begin : g_bad_regen_frames
        $error("tank_hit_resolver: REGEN_FRAMES must be 1..1023");
    end

    // Box overlap, edges touching included. The distance is larger minus smaller,
    // so it never goes negative. The half-size sum is widened to 11 bits so two
    // large boxes cannot wrap into a false miss.
    function automatic logic overlap(
        input logic [9:0] ax,
        input logic [9:0] ay,
        input logic [9:0] a_s,
        input logic [9:0] bx,
        input logic [9:0] by,
        input logic [9:0] b_s
    );
        logic [9:0]  dx;
        logic [9:0]  dy;
        logic [10:0] reach;
        dx    = (ax >= bx) ? (ax - bx) : (bx - ax);
        dy    = (ay >= by) ? (ay - by) : (by - ay);
        reach = {1'b0, a_s} + {1'b0, b_s};
        return ({1'b0, dx} <= reach) && ({1'b0, dy} <= reach);
    endfunction

    function automatic logic [2:0] health_dec(input logic [2:0] h);
        return (h == 3'd0) ? 3'd0 : (h - 3'd1);
    endfunction

    // Registered state (p1) and its next value (p0).
    state_t     state_p1,      state_p0;
    logic [2:0] health_p1,     health_p0;
    logic       armor_p1,      armor_p0;
    logic       consumed_p1,   consumed_p0;
    logic [7:0] inv_cnt_p1,    inv_cnt_p0;
    logic       player_hit_p1, player_hit_p0;
    logic       armor_hit_p1,  armor_hit_p0;
    logic       bb_hit_p1,     bb_hit_p0;
`ifdef HIT_REGEN_EN
    localparam logic [9:0] REGEN_LAST = 10'(REGEN_FRAMES - 1);
    logic [9:0] regen_cnt_p1,  regen_cnt_p0;
`endif

    logic tank_ov;
    logic bb_ov;
    logic bb_ev;
    logic tank_ev;

    assign tank_ov = bullet_on &&
                     overlap(BulletX, BulletY, BulletS, TankX, TankY, TankS);
    assign bb_ov   = bullet_on && own_bullet_on &&
                     overlap(BulletX, BulletY, BulletS, OwnBulletX, OwnBulletY, OwnBulletS);

    // One event per shot: a consumed bullet is inert until it leaves flight.
    // A bullet collision outranks a tank hit in the same frame and fires in
    // every state; a tank hit only lands while ALIVE.
    assign bb_ev   = bb_ov && !consumed_p1;
    assign tank_ev = tank_ov && !consumed_p1 && !bb_ov && (state_p1 == ALIVE);

    // ---- stage p0: next-state and strobe evaluation ----
    always_comb begin
        state_p0      = state_p1;
        health_p0     = health_p1;
        armor_p0      = armor_p1;
        consumed_p0   = consumed_p1;
        inv_cnt_p0    = inv_cnt_p1;
        player_hit_p0 = 1'b0;
        armor_hit_p0  = 1'b0;
        bb_hit_p0     = bb_ev;
`ifdef HIT_REGEN_EN
        regen_cnt_p0  = regen_cnt_p1;
`endif

        case (state_p1)
            ALIVE: begin
                if (tank_ev) begin
                    inv_cnt_p0 = 8'd0;
                    if (armor_p1) begin
                        armor_hit_p0 = 1'b1;
                        armor_p0     = 1'b0;
                        state_p0     = INVULN;
                    end else begin
                        player_hit_p0 = 1'b1;
                        health_p0     = health_dec(health_p1);
                        state_p0      = (health_p1 <= 3'd1) ? DEAD : INVULN;
                    end
`ifdef HIT_REGEN_EN
                    regen_cnt_p0 = 10'd0;
                end else if (health_p1 >= HEALTH_MAX) begin
                    regen_cnt_p0 = 10'd0;
                end else if (regen_cnt_p1 == REGEN_LAST) begin
                    regen_cnt_p0 = 10'd0;
                    health_p0    = health_p1 + 3'd1;
                end else begin
                    regen_cnt_p0 = regen_cnt_p1 + 10'd1;
`endif
                end
            end
            INVULN: begin
                // Opponent bullets pass straight through here.
                if (inv_cnt_p1 == INVULN_LAST) begin
                    inv_cnt_p0 = 8'd0;
                    state_p0   = ALIVE;
                end else begin
                    inv_cnt_p0 = inv_cnt_p1 + 8'd1;
                end
            end
            DEAD: begin
                state_p0 = DEAD;
            end
            default: begin
                state_p0 = ALIVE;
            end
        endcase

        // Pickup lands after the hit, so a same-frame hit consumes the old armor
        // and the tank still leaves the frame armored. A dead tank takes none.
        if (armor_pickup && (state_p0 != DEAD)) begin
            armor_p0 = 1'b1;
        end

        if (!bullet_on) begin
            consumed_p0 = 1'b0;
        end else if (bb_ev || tank_ev) begin
            consumed_p0 = 1'b1;
        end
    end

    // ---- stage p1: registered state and strobes ----
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_p1      <= ALIVE;
            health_p1     <= HEALTH_MAX;
            armor_p1      <= 1'b0;
            consumed_p1   <= 1'b0;
            inv_cnt_p1    <= 8'd0;
            player_hit_p1 <= 1'b0;
            armor_hit_p1  <= 1'b0;
            bb_hit_p1     <= 1'b0;
`ifdef HIT_REGEN_EN
            regen_cnt_p1  <= 10'd0;
`endif
        end else begin
            state_p1      <= state_p0;
            health_p1     <= health_p0;
            armor_p1      <= armor_p0;
            consumed_p1   <= consumed_p0;
            inv_cnt_p1    <= inv_cnt_p0;
            player_hit_p1 <= player_hit_p0;
            armor_hit_p1  <= armor_hit_p0;
            bb_hit_p1     <= bb_hit_p0;
`ifdef HIT_REGEN_EN
            regen_cnt_p1  <= regen_cnt_p0;
`endif
        end
    end

    assign player_hit           = player_hit_p1;
    assign armor_hit            = armor_hit_p1;
    assign bullet_on_bullet_hit = bb_hit_p1;
    assign health               = health_p1;
    assign armor_on             = armor_p1;
    assign invuln               = (state_p1 == INVULN);
    assign dead                 = (state_p1 == DEAD);

endmodule

// File: tb/tb_tank_hit_resolver.sv
// Bench for tank_hit_resolver. It runs directed scenarios and then randomized
// frames. A frame-level reference model tracks health, armor, frames of
// invulnerability left, death and the one-event-per-shot flag.
module tb_tank_hit_resolver;

    localparam int MAXH = 3;
    localparam int INV  = 60;

    logic       frame_clk;
    logic       Reset_n;
    logic [9:0] BulletX, BulletY, BulletS;
    logic       bullet_on;
    logic [9:0] OwnBulletX, OwnBulletY, OwnBulletS;
    logic       own_bullet_on;
    logic [9:0] TankX, TankY, TankS;
    logic       armor_pickup;
    logic       player_hit, armor_hit, bullet_on_bullet_hit;
    logic [2:0] health;
    logic       armor_on, invuln, dead;

    int n_assert = 0;
    int n_fail   = 0;

    // reference model state
    int m_health;
    int m_inv_left;
    bit m_armor, m_dead, m_consumed;
    bit e_ph, e_ah, e_bb;

    tank_hit_resolver dut (
        .frame_clk(frame_clk), .Reset_n(Reset_n),
        .BulletX(BulletX), .BulletY(BulletY), .BulletS(BulletS), .bullet_on(bullet_on),
        .OwnBulletX(OwnBulletX), .OwnBulletY(OwnBulletY), .OwnBulletS(OwnBulletS),
        .own_bullet_on(own_bullet_on),
        .TankX(TankX), .TankY(TankY), .TankS(TankS),
        .armor_pickup(armor_pickup),
        .player_hit(player_hit), .armor_hit(armor_hit),
        .bullet_on_bullet_hit(bullet_on_bullet_hit),
        .health(health), .armor_on(armor_on), .invuln(invuln), .dead(dead)
    );

    initial begin
        frame_clk = 1'b0;
        forever #5 frame_clk = ~frame_clk;
    end

    function automatic bit boxes_touch(int ax, int ay, int as_, int bx, int by, int bs);
        int dx;
        int dy;
        dx = ax - bx;
        dy = ay - by;
        if (dx < 0) dx = -dx;
        if (dy < 0) dy = -dy;
        return (dx <= as_ + bs) && (dy <= as_ + bs);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_health   = MAXH;
        m_inv_left = 0;
        m_armor    = 0;
        m_dead     = 0;
        m_consumed = 0;
        e_ph = 0; e_ah = 0; e_bb = 0;
    endtask

    task automatic model_step();
        bit bb, tk, fired, was_inv;
        bb = bullet_on && own_bullet_on &&
             boxes_touch(BulletX, BulletY, BulletS, OwnBulletX, OwnBulletY, OwnBulletS);
        tk = bullet_on && boxes_touch(BulletX, BulletY, BulletS, TankX, TankY, TankS);
        e_ph = 0; e_ah = 0; e_bb = 0; fired = 0;
        was_inv = (m_inv_left > 0);
        if (was_inv) m_inv_left--;
        if (!m_consumed) begin
            if (bb) begin
                e_bb = 1; fired = 1;
            end else if (tk && !m_dead && !was_inv) begin
                fired = 1;
                if (m_armor) begin
                    e_ah = 1; m_armor = 0; m_inv_left = INV;
                end else begin
                    e_ph = 1;
                    m_health = (m_health > 0) ? m_health - 1 : 0;
                    if (m_health == 0) m_dead = 1;
                    else m_inv_left = INV;
                end
            end
        end
        if (!bullet_on) m_consumed = 0;
        else if (fired) m_consumed = 1;
        if (armor_pickup && !m_dead) m_armor = 1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".player_hit"}, player_hit, e_ph);
        chk({tag, ".armor_hit"}, armor_hit, e_ah);
        chk({tag, ".bb_hit"}, bullet_on_bullet_hit, e_bb);
        chk({tag, ".health"}, health, m_health);
        chk({tag, ".armor_on"}, armor_on, m_armor);
        chk({tag, ".invuln"}, invuln, m_inv_left > 0);
        chk({tag, ".dead"}, dead, m_dead);
    endtask

    task automatic step(input string tag);
        @(posedge frame_clk);
        #1;
        model_step();
        check_all(tag);
    endtask

    // Reset asserted between edges; outputs must clear without a clock.
    task automatic do_reset(input string tag);
        Reset_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        #1;
        Reset_n = 1'b1;
    endtask

    task automatic set_bullet(input int x, input int y, input int s, input bit on);
        BulletX = 10'(x); BulletY = 10'(y); BulletS = 10'(s); bullet_on = on;
    endtask

    task automatic set_own(input int x, input int y, input int s, input bit on);
        OwnBulletX = 10'(x); OwnBulletY = 10'(y); OwnBulletS = 10'(s); own_bullet_on = on;
    endtask

    task automatic set_tank(input int x, input int y, input int s);
        TankX = 10'(x); TankY = 10'(y); TankS = 10'(s);
    endtask

    initial begin
        int inv_len;
        Reset_n = 1'b0;
        set_bullet(0, 0, 0, 0);
        set_own(500, 500, 0, 0);
        set_tank(100, 100, 8);
        armor_pickup = 1'b0;
        model_reset();

        // 1: reset state
        @(posedge frame_clk);
        @(posedge frame_clk);
        #1;
        check_all("reset");
        chk("reset.health_const", health, 3);
        #1;
        Reset_n = 1'b1;
        step("idle");

        // 2: unarmored hit, then invulnerability length, then no second hit
        set_bullet(104, 100, 2, 1);
        step("t2.hit");
        chk("t2.player_hit", player_hit, 1);
        chk("t2.health", health, 2);
        inv_len = 1;
        for (int i = 0; i < 100 && invuln; i++) begin
            step("t2.hold");
            if (invuln) inv_len++;
        end
        chk("t2.invuln_len", inv_len, INV);
        repeat (5) step("t2.after");
        chk("t2.no_second_hit", health, 2);
        set_bullet(104, 100, 2, 0);
        step("t2.off");

        // 3: armor absorbs the hit
        do_reset("t3.reset");
        armor_pickup = 1'b1;
        step("t3.pickup");
        armor_pickup = 1'b0;
        chk("t3.armor_on", armor_on, 1);
        set_bullet(104, 100, 2, 1);
        step("t3.hit");
        chk("t3.armor_hit", armor_hit, 1);
        chk("t3.health", health, 3);
        chk("t3.armor_off", armor_on, 0);
        chk("t3.invuln", invuln, 1);
        set_bullet(104, 100, 2, 0);
        repeat (INV + 2) step("t3.wait");

        // 3b: pickup in the same frame as a hit, then no armor stacking
        armor_pickup = 1'b1;
        set_bullet(104, 100, 2, 1);
        step("t3b.hit_pickup");
        chk("t3b.player_hit", player_hit, 1);
        chk("t3b.armor_after", armor_on, 1);
        set_bullet(104, 100, 2, 0);
        step("t3b.pickup_again");
        armor_pickup = 1'b0;
        repeat (INV + 2) step("t3b.wait");
        set_bullet(104, 100, 2, 1);
        step("t3b.armored_hit");
        set_bullet(104, 100, 2, 0);
        repeat (INV + 2) step("t3b.wait2");
        set_bullet(104, 100, 2, 1);
        step("t3b.bare_hit");
        chk("t3b.health", health, 1);
        set_bullet(104, 100, 2, 0);

        // 4: three hits spaced 70 frames apart -> dead, then inert
        do_reset("t4.reset");
        for (int k = 0; k < 3; k++) begin
            set_bullet(104, 100, 2, 1);
            step("t4.hit");
            chk("t4.health", health, 2 - k);
            set_bullet(104, 100, 2, 0);
            repeat (69) step("t4.gap");
        end
        chk("t4.dead", dead, 1);
        armor_pickup = 1'b1;
        for (int k = 0; k < 6; k++) begin
            set_bullet(104, 100, 2, k[0]);
            step("t4.dead_overlap");
        end
        armor_pickup = 1'b0;
        chk("t4.dead_no_armor", armor_on, 0);
        set_own(104, 100, 2, 1);
        set_bullet(104, 100, 2, 1);
        step("t4.dead_bb");
        chk("t4.dead_bb_fires", bullet_on_bullet_hit, 1);
        set_bullet(104, 100, 2, 0);
        set_own(500, 500, 0, 0);
        step("t4.clear");

        // 5: bullet collision outranks the tank hit
        do_reset("t5.reset");
        set_own(104, 100, 2, 1);
        set_bullet(104, 100, 2, 1);
        step("t5.bb");
        chk("t5.bb_hit", bullet_on_bullet_hit, 1);
        chk("t5.no_player_hit", player_hit, 0);
        repeat (3) step("t5.hold");
        set_own(500, 500, 0, 0);
        repeat (3) step("t5.own_gone");
        chk("t5.health", health, 3);
        set_bullet(104, 100, 2, 0);
        step("t5.off");

        // 6: reset mid-INVULN with health 1 and mid-pulse
        do_reset("t6.reset");
        set_bullet(104, 100, 2, 1);
        step("t6.hit1");
        set_bullet(104, 100, 2, 0);
        repeat (69) step("t6.gap");
        set_bullet(104, 100, 2, 1);
        step("t6.hit2");
        chk("t6.health1", health, 1);
        chk("t6.pulse_high", player_hit, 1);
        do_reset("t6.midpulse");
        chk("t6.health_restored", health, 3);
        chk("t6.invuln_clear", invuln, 0);
        chk("t6.pulse_clear", player_hit, 0);
        set_bullet(104, 100, 2, 0);
        step("t6.off");

        // Overlap boundaries: one past the edge misses, the edge itself hits
        do_reset("bnd.reset");
        set_bullet(111, 100, 2, 1);
        step("bnd.x_plus_miss");
        set_bullet(110, 100, 2, 1);
        step("bnd.x_plus_edge");
        chk("bnd.x_edge_hit", player_hit, 1);
        set_bullet(110, 100, 2, 0);
        do_reset("bnd.reset2");
        set_bullet(89, 100, 2, 1);
        step("bnd.x_minus_miss");
        set_bullet(90, 100, 2, 1);
        step("bnd.x_minus_edge");
        set_bullet(90, 100, 2, 0);
        do_reset("bnd.reset3");
        set_bullet(100, 111, 2, 1);
        step("bnd.y_miss");
        set_bullet(100, 90, 2, 1);
        step("bnd.y_edge");
        set_bullet(100, 90, 2, 0);
        // Large boxes whose half-size sum exceeds 10 bits
        do_reset("bnd.reset4");
        set_tank(10, 10, 600);
        set_bullet(1010, 10, 500, 1);
        step("bnd.wide");
        chk("bnd.wide_hit", player_hit, 1);
        set_bullet(1010, 10, 500, 0);
        step("bnd.wide_off");
        set_tank(100, 100, 8);

        // Randomized frames against the model, with periodic resets
        do_reset("rand.reset");
        for (int i = 0; i < 1500; i++) begin
            if (i % 250 == 249) do_reset("rand.reset");
            set_bullet(85 + $urandom_range(0, 30), 90 + $urandom_range(0, 20),
                       $urandom_range(0, 4), $urandom_range(0, 9) < 7);
            set_own(88 + $urandom_range(0, 24), 92 + $urandom_range(0, 16),
                    $urandom_range(0, 3), $urandom_range(0, 1) == 1);
            armor_pickup = ($urandom_range(0, 19) == 0);
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
